instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields (opcode, funct, rs, rt, rd, imm) over a valid/ready handshake.
- Packs each field bundle into a 32-bit MIPS instruction word and writes it to sequential instruction-memory addresses.
- Used as the testbench and boot-time program loader that fills IMEM before the pipeline is released from stall.
- Rejects encodings the decoder does not support and flags them.

Parameters:
- PWIDTH, 8, word-address width of the IMEM write port (depth 2^PWIDTH words).
- Field and word widths come from the shared header: `IWIDTH (32), `OPCODE_WIDTH (6), `FUNCT_WIDTH (6), `AWIDTH (5), `IMM_WIDTH (16).

Ports:
- e_i_clk  in  1  clock, rising edge.
- e_i_rst_n  in  1  asynchronous active-low reset.
- e_i_start  in  1  one-cycle pulse; latches e_i_base_addr, enters LOAD.
- e_i_base_addr  in  PWIDTH  first IMEM word address.
- e_i_valid  in  1  field bundle valid.
- e_o_ready  out  1  encoder can accept a bundle.
- e_i_last  in  1  bundle is the final instruction of the program.
- e_i_opcode  in  6  opcode.
- e_i_funct  in  6  funct (R-type only).
- e_i_addr_rs / e_i_addr_rt / e_i_addr_rd  in  5 each  register fields.
- e_i_imm  in  16  immediate / branch offset.
- e_o_wr_en  out  1  IMEM write strobe.
- e_o_wr_addr  out  PWIDTH  IMEM write address.
- e_o_wr_data  out  32  encoded instruction word.
- e_o_count  out  PWIDTH+1  words written since last start.
- e_o_err  out  1  sticky: an illegal bundle was dropped.
- e_o_full  out  1  address space exhausted.
- e_o_done  out  1  one-cycle pulse when the program is complete.

Behaviour:
- Reset (async, e_i_rst_n=0): state IDLE, all outputs 0, pointer 0, count 0. Reset mid-LOAD drops any pending write; e_o_wr_en=0 immediately.
- States:
  - IDLE -> LOAD on e_i_start.
  - LOAD -> DONE when a bundle with e_i_last is accepted.
  - LOAD -> FULL when the write to address 2^PWIDTH-1 is accepted without last.
  - FULL holds until e_i_start (restart, same as IDLE).
  - DONE -> IDLE after one cycle; e_o_done=1 during the DONE cycle.
  - e_i_start is honoured in IDLE, DONE and FULL only. It is ignored in LOAD.
- Start clears count, err and full, and sets pointer = e_i_base_addr.
- Handshake:
  - e_o_ready = (state==LOAD).
  - A transfer occurs when e_i_valid && e_o_ready.
  - Fields must hold while valid && !ready.
- Legal encodings:
  - R-type (opcode 0x00) with funct in {ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26} -> {6'h00, rs, rt, rd, 5'b0, funct}.
  - I-type opcodes {LOAD 0x23, STORE 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E} -> {opcode, rs, rt, imm}. rd and funct are ignored.
  - Any other opcode, or R-type with another funct, is illegal.
- Illegal transfer: e_o_err set (sticky). No write. Pointer and count unchanged. If e_i_last is set, the FSM still goes to DONE.
- Latency: a legal transfer at edge N produces e_o_wr_en=1 with registered e_o_wr_addr/e_o_wr_data for exactly the cycle after edge N. Back-to-back transfers produce back-to-back writes. Throughput is 1 word/cycle.
- After each write, pointer += 1 and count += 1. The pointer never wraps: reaching the top address asserts e_o_full and deasserts ready.
- Last bundle written to the top address: go to DONE (not FULL); e_o_full is still set.
- e_o_wr_en=0 whenever no write is issued; wr_addr/wr_data hold their last values.

Test Plan:
- Reset, start base=0x10, send add rs=1 rt=2 rd=3 (op 0x00, funct 0x20), last=0 -> next cycle wr_en=1, addr=0x10, data=0x00221820, count=1.
- Back-to-back: addi rt=5 rs=0 imm=7; lw rt=4 rs=1 imm=8; sw rt=4 rs=1 imm=12; beq rs=1 rt=2 imm=0xFFFE (last) -> consecutive writes 0x20050007, 0x8C240008, 0xAC24000C, 0x1022FFFE at addrs 0x11–0x14, then done pulse, state IDLE.
- Illegal opcode 0x3F, then R-type funct 0x2A -> no wr_en, err=1 sticky, count unchanged. A following legal or bundle (funct 0x25, rs=1 rt=2 rd=3) writes 0x00221825.
- PWIDTH=2, base=2, two legal bundles without last -> writes at addr 2 and 3, then full=1, ready=0. Later start clears full and count.
- Assert e_i_rst_n=0 in the cycle after a transfer -> wr_en never asserts, all outputs 0. After release, ready=0 until start.
- Hold valid=1 in IDLE, then pulse start -> nothing is accepted before LOAD. The first write occurs one cycle after the first accepting edge.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Bundle/IMEM-write interface of the instruction encoder-loader.
// The master (program source) drives field bundles; the slave (encoder) drives IMEM writes and status.
interface instr_encoder_loader_if #(
    parameter int PWIDTH = 8
);
    logic              e_i_start;
    logic [PWIDTH-1:0] e_i_base_addr;
    logic              e_i_valid;
    logic              e_o_ready;
    logic              e_i_last;
    logic [5:0]        e_i_opcode;
    logic [5:0]        e_i_funct;
    logic [4:0]        e_i_addr_rs;
    logic [4:0]        e_i_addr_rt;
    logic [4:0]        e_i_addr_rd;
    logic [15:0]       e_i_imm;
    logic              e_o_wr_en;
    logic [PWIDTH-1:0] e_o_wr_addr;
    logic [31:0]       e_o_wr_data;
    logic [PWIDTH:0]   e_o_count;
    logic              e_o_err;
    logic              e_o_full;
    logic              e_o_done;

    modport master (
        output e_i_start, e_i_base_addr, e_i_valid, e_i_last,
        output e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd, e_i_imm,
        input  e_o_ready, e_o_wr_en, e_o_wr_addr, e_o_wr_data,
        input  e_o_count, e_o_err, e_o_full, e_o_done
    );

    modport slave (
        input  e_i_start, e_i_base_addr, e_i_valid, e_i_last,
        input  e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd, e_i_imm,
        output e_o_ready, e_o_wr_en, e_o_wr_addr, e_o_wr_data,
        output e_o_count, e_o_err, e_o_full, e_o_done
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS field bundles into 32-bit words and writes them to sequential IMEM
// addresses; used to load a program before the pipeline leaves stall. Illegal bundles are dropped.
module instr_encoder_loader #(
    parameter int PWIDTH = 8
) (
    input logic                  e_i_clk,
    input logic                  e_i_rst_n,
    instr_encoder_loader_if.slave bus
);
    localparam int IWIDTH       = 32;
    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;
    localparam int AWIDTH       = 5;
    localparam int IMM_WIDTH    = 16;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_WIDTH-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_WIDTH-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_WIDTH-1:0] FN_XOR = 6'h26;

    localparam logic [PWIDTH-1:0] TOP_ADDR = '1;
    localparam logic [PWIDTH-1:0] PTR_ONE  = {{(PWIDTH-1){1'b0}}, 1'b1};
    localparam logic [PWIDTH:0]   CNT_ONE  = {{PWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PWIDTH-1:0]   ptr_q, ptr_d;
    logic [PWIDTH:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                full_q, full_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [PWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [IWIDTH-1:0]   wr_data_q, wr_data_d;

    logic                legal;
    logic [IWIDTH-1:0]   enc_word;
    logic                transfer;
    logic                at_top;

    // Encoding table: only the subset the decoder understands is legal.
    always_comb begin
        legal    = 1'b0;
        enc_word = '0;
        case (bus.e_i_opcode)
            OP_RTYPE: begin
                case (bus.e_i_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: legal = 1'b1;
                    default:                               legal = 1'b0;
                endcase
                enc_word = {OP_RTYPE, bus.e_i_addr_rs, bus.e_i_addr_rt, bus.e_i_addr_rd,
                            {AWIDTH{1'b0}}, bus.e_i_funct};
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                legal    = 1'b1;
                enc_word = {bus.e_i_opcode, bus.e_i_addr_rs, bus.e_i_addr_rt,
                            bus.e_i_imm[IMM_WIDTH-1:0]};
            end
            default: begin
                legal    = 1'b0;
                enc_word = '0;
            end
        endcase
    end

    assign transfer = bus.e_i_valid && ready_q;
    assign at_top   = (ptr_q == TOP_ADDR);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        full_d    = full_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_LOAD: begin
                if (transfer) begin
                    if (legal) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = enc_word;
                        count_d   = count_q + CNT_ONE;
                        // The pointer parks on the top word instead of wrapping.
                        if (at_top) begin
                            full_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end

                    if (bus.e_i_last) begin
                        state_d = S_DONE;
                    end else if (legal && at_top) begin
                        state_d = S_FULL;
                    end
                end
            end
            default: begin
                // IDLE, DONE and FULL all accept a (re)start.
                if (bus.e_i_start) begin
                    state_d = S_LOAD;
                    ptr_d   = bus.e_i_base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        ready_d = (state_d == S_LOAD);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge e_i_clk or negedge e_i_rst_n) begin
        if (!e_i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            full_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            full_q    <= full_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.e_o_ready   = ready_q;
    assign bus.e_o_wr_en   = wr_en_q;
    assign bus.e_o_wr_addr = wr_addr_q;
    assign bus.e_o_wr_data = wr_data_q;
    assign bus.e_o_count   = count_q;
    assign bus.e_o_err     = err_q;
    assign bus.e_o_full    = full_q;
    assign bus.e_o_done    = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: a PWIDTH=8 loader checked through a write scoreboard, plus a
// PWIDTH=2 loader for address-exhaustion behaviour.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader_if #(.PWIDTH(8)) bus_a ();
    instr_encoder_loader_if #(.PWIDTH(2)) bus_b ();

    instr_encoder_loader #(.PWIDTH(8)) dut_a (.e_i_clk(clk), .e_i_rst_n(rst_n), .bus(bus_a.slave));
    instr_encoder_loader #(.PWIDTH(2)) dut_b (.e_i_clk(clk), .e_i_rst_n(rst_n), .bus(bus_b.slave));

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] exp_ptr;
    logic [8:0] exp_count;

    // Every write strobe from dut_a must match the oldest expected write.
    always @(negedge clk) begin
        if (bus_a.e_o_wr_en === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus_a.e_o_wr_addr, bus_a.e_o_wr_data);
            end else begin
                wr_t exp_w;
                exp_w = sb_q.pop_front();
                if (bus_a.e_o_wr_addr !== exp_w.addr || bus_a.e_o_wr_data !== exp_w.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus_a.e_o_wr_addr, bus_a.e_o_wr_data, exp_w.addr, exp_w.data);
                end else begin
                    $display("write addr=%h data=%h", bus_a.e_o_wr_addr, bus_a.e_o_wr_data);
                end
            end
        end
    end

    task automatic init_inputs();
        bus_a.e_i_start = 0; bus_a.e_i_base_addr = '0; bus_a.e_i_valid = 0; bus_a.e_i_last = 0;
        bus_a.e_i_opcode = '0; bus_a.e_i_funct = '0; bus_a.e_i_addr_rs = '0;
        bus_a.e_i_addr_rt = '0; bus_a.e_i_addr_rd = '0; bus_a.e_i_imm = '0;
        bus_b.e_i_start = 0; bus_b.e_i_base_addr = '0; bus_b.e_i_valid = 0; bus_b.e_i_last = 0;
        bus_b.e_i_opcode = '0; bus_b.e_i_funct = '0; bus_b.e_i_addr_rs = '0;
        bus_b.e_i_addr_rt = '0; bus_b.e_i_addr_rd = '0; bus_b.e_i_imm = '0;
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_a(input logic [7:0] base);
        bus_a.e_i_start = 1; bus_a.e_i_base_addr = base;
        @(negedge clk);
        bus_a.e_i_start = 0;
        exp_ptr = base;
        exp_count = '0;
        checks++;
        if (bus_a.e_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: got %b, required 1", bus_a.e_o_ready);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid dropped.
    task automatic send_a(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                          input logic last, input logic is_legal, input logic [31:0] exp_data,
                          output int waited);
        bus_a.e_i_opcode = op; bus_a.e_i_funct = fn; bus_a.e_i_addr_rs = rs;
        bus_a.e_i_addr_rt = rt; bus_a.e_i_addr_rd = rd; bus_a.e_i_imm = imm;
        bus_a.e_i_last = last; bus_a.e_i_valid = 1;
        waited = 0;
        while (bus_a.e_o_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus_a.e_o_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", bus_a.e_o_ready, waited);
            bus_a.e_i_valid = 0; bus_a.e_i_last = 0;
            return;
        end
        if (is_legal) begin
            sb_q.push_back('{addr: exp_ptr, data: exp_data});
            exp_ptr++;
            exp_count++;
        end
        @(negedge clk);
        bus_a.e_i_valid = 0; bus_a.e_i_last = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus_a.e_o_ready, bus_a.e_o_wr_en, bus_a.e_o_err, bus_a.e_o_full, bus_a.e_o_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy/wen/err/full/done=%b, required 00000",
                     {bus_a.e_o_ready, bus_a.e_o_wr_en, bus_a.e_o_err, bus_a.e_o_full, bus_a.e_o_done});
        end
        checks++;
        if (bus_a.e_o_count !== 9'd0 || bus_a.e_o_wr_addr !== 8'd0 || bus_a.e_o_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got count=%0d addr=%h data=%h, required 0 0 0",
                     bus_a.e_o_count, bus_a.e_o_wr_addr, bus_a.e_o_wr_data);
        end
    endtask

    task automatic test_basic();
        int w;
        start_a(8'h10);
        send_a(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'h00221820, w);
        checks++;
        if (bus_a.e_o_count !== 9'd1) begin
            errors++;
            $display("FAIL basic_count: got %0d, required 1", bus_a.e_o_count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int total_wait = 0;
        send_a(6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 16'h0007, 1'b0, 1'b1, 32'h20050007, w); total_wait += w;
        send_a(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 16'h0008, 1'b0, 1'b1, 32'h8C240008, w); total_wait += w;
        send_a(6'h2B, 6'h00, 5'd1, 5'd4, 5'd0, 16'h000C, 1'b0, 1'b1, 32'hAC24000C, w); total_wait += w;
        send_a(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 16'hFFFE, 1'b1, 1'b1, 32'h1022FFFE, w); total_wait += w;
        checks++;
        if (total_wait != 0) begin
            errors++;
            $display("FAIL b2b_stall: got %0d wait cycles, required 0", total_wait);
        end
        checks++;
        if (bus_a.e_o_done !== 1'b1 || bus_a.e_o_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got done=%b ready=%b, required 1 0", bus_a.e_o_done, bus_a.e_o_ready);
        end
        checks++;
        if (bus_a.e_o_count !== 9'd5) begin
            errors++;
            $display("FAIL b2b_count: got %0d, required 5", bus_a.e_o_count);
        end
        @(negedge clk);
        checks++;
        if (bus_a.e_o_done !== 1'b0 || bus_a.e_o_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got done=%b ready=%b, required 0 0", bus_a.e_o_done, bus_a.e_o_ready);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending writes, required 0", sb_q.size());
        end
    endtask

    task automatic test_illegal();
        int w;
        start_a(8'h40);
        send_a(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 1'b0, 32'h0, w);
        send_a(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b0, 32'h0, w);
        checks++;
        if (bus_a.e_o_err !== 1'b1 || bus_a.e_o_count !== 9'd0) begin
            errors++;
            $display("FAIL illegal_err: got err=%b count=%0d, required 1 0", bus_a.e_o_err, bus_a.e_o_count);
        end
        send_a(6'h00, 6'h25, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 32'h00221825, w);
        checks++;
        if (bus_a.e_o_err !== 1'b1 || bus_a.e_o_count !== 9'd1) begin
            errors++;
            $display("FAIL illegal_sticky: got err=%b count=%0d, required 1 1", bus_a.e_o_err, bus_a.e_o_count);
        end
        send_a(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 32'h0, w);
        checks++;
        if (bus_a.e_o_done !== 1'b1 || bus_a.e_o_count !== 9'd1) begin
            errors++;
            $display("FAIL illegal_last: got done=%b count=%0d, required 1 1", bus_a.e_o_done, bus_a.e_o_count);
        end
        @(negedge clk);
    endtask

    task automatic test_full();
        bus_b.e_i_start = 1; bus_b.e_i_base_addr = 2'd2;
        @(negedge clk);
        bus_b.e_i_start = 0;
        bus_b.e_i_opcode = 6'h00; bus_b.e_i_funct = 6'h20;
        bus_b.e_i_addr_rs = 5'd1; bus_b.e_i_addr_rt = 5'd2; bus_b.e_i_addr_rd = 5'd3;
        bus_b.e_i_valid = 1;
        @(negedge clk);
        checks++;
        if (bus_b.e_o_wr_en !== 1'b1 || bus_b.e_o_wr_addr !== 2'd2 || bus_b.e_o_wr_data !== 32'h00221820) begin
            errors++;
            $display("FAIL full_write0: got wen=%b addr=%0d data=%h, required 1 2 00221820",
                     bus_b.e_o_wr_en, bus_b.e_o_wr_addr, bus_b.e_o_wr_data);
        end
        bus_b.e_i_opcode = 6'h08; bus_b.e_i_addr_rs = 5'd0; bus_b.e_i_addr_rt = 5'd5; bus_b.e_i_imm = 16'h0007;
        @(negedge clk);
        bus_b.e_i_valid = 0;
        checks++;
        if (bus_b.e_o_wr_en !== 1'b1 || bus_b.e_o_wr_addr !== 2'd3 || bus_b.e_o_wr_data !== 32'h20050007) begin
            errors++;
            $display("FAIL full_write1: got wen=%b addr=%0d data=%h, required 1 3 20050007",
                     bus_b.e_o_wr_en, bus_b.e_o_wr_addr, bus_b.e_o_wr_data);
        end
        checks++;
        if (bus_b.e_o_full !== 1'b1 || bus_b.e_o_ready !== 1'b0 || bus_b.e_o_count !== 3'd2) begin
            errors++;
            $display("FAIL full_flag: got full=%b ready=%b count=%0d, required 1 0 2",
                     bus_b.e_o_full, bus_b.e_o_ready, bus_b.e_o_count);
        end
        @(negedge clk);
        checks++;
        if (bus_b.e_o_wr_en !== 1'b0 || bus_b.e_o_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: got wen=%b full=%b, required 0 1", bus_b.e_o_wr_en, bus_b.e_o_full);
        end
        bus_b.e_i_start = 1; bus_b.e_i_base_addr = 2'd0;
        @(negedge clk);
        bus_b.e_i_start = 0;
        checks++;
        if (bus_b.e_o_full !== 1'b0 || bus_b.e_o_count !== 3'd0 || bus_b.e_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_restart: got full=%b count=%0d ready=%b, required 0 0 1",
                     bus_b.e_o_full, bus_b.e_o_count, bus_b.e_o_ready);
        end
    endtask

    task automatic test_reset_mid();
        start_a(8'h00);
        bus_a.e_i_opcode = 6'h00; bus_a.e_i_funct = 6'h22;
        bus_a.e_i_addr_rs = 5'd4; bus_a.e_i_addr_rt = 5'd5; bus_a.e_i_addr_rd = 5'd6;
        bus_a.e_i_valid = 1;
        @(posedge clk);
        #1 rst_n = 0;
        bus_a.e_i_valid = 0;
        @(negedge clk);
        checks++;
        if ({bus_a.e_o_wr_en, bus_a.e_o_ready, bus_a.e_o_done, bus_a.e_o_err, bus_a.e_o_full} !== 5'b0 ||
            bus_a.e_o_count !== 9'd0 || bus_a.e_o_wr_addr !== 8'd0 || bus_a.e_o_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got wen=%b ready=%b count=%0d addr=%h data=%h, required all 0",
                     bus_a.e_o_wr_en, bus_a.e_o_ready, bus_a.e_o_count, bus_a.e_o_wr_addr, bus_a.e_o_wr_data);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus_a.e_o_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_ready: got %b, required 0", bus_a.e_o_ready);
            end
        end
    endtask

    task automatic test_valid_in_idle();
        bus_a.e_i_opcode = 6'h0E; bus_a.e_i_funct = 6'h00;
        bus_a.e_i_addr_rs = 5'd2; bus_a.e_i_addr_rt = 5'd3; bus_a.e_i_addr_rd = 5'd0;
        bus_a.e_i_imm = 16'h00FF; bus_a.e_i_last = 1; bus_a.e_i_valid = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.e_o_count !== 9'd0 || bus_a.e_o_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_accept: got count=%0d ready=%b, required 0 0", bus_a.e_o_count, bus_a.e_o_ready);
        end
        start_a(8'h80);
        checks++;
        if (bus_a.e_o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_early_write: got wen=%b, required 0", bus_a.e_o_wr_en);
        end
        sb_q.push_back('{addr: 8'h80, data: 32'h384300FF});
        @(negedge clk);
        bus_a.e_i_valid = 0; bus_a.e_i_last = 0;
        checks++;
        if (bus_a.e_o_wr_en !== 1'b1 || bus_a.e_o_count !== 9'd1 || bus_a.e_o_done !== 1'b1) begin
            errors++;
            $display("FAIL idle_first_write: got wen=%b count=%0d done=%b, required 1 1 1",
                     bus_a.e_o_wr_en, bus_a.e_o_count, bus_a.e_o_done);
        end
        @(negedge clk);
    endtask

    initial begin
        init_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_valid_in_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending writes, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
